mem_lsu: RTL and testbench

- Parametrised successor to the single-cycle data memory.
- Word-organised RAM behind a valid/ready load/store front end that serves the RISC-V datapath.
- Handles byte, half and word accesses, signed and unsigned, with range and alignment checking.
- Misaligned accesses are optionally split into two word accesses by a small FSM.

---
 rtl/mem_lsu.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: word-organised data RAM behind a valid/ready load/store front end.
// Handles byte/half/word loads and stores (signed and unsigned) with range and
// alignment checking. Responses are registered, in order, one pulse each.
//
// Optional feature MEM_LSU_MISALIGNED_EN: when defined, an in-range misaligned
// access is split into two word accesses (latency 2). When undefined, it
// returns an ALIGN error.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (accepted on valid & ready)
//   req_we               1 = store, 0 = load
//   req_addr [AW]        byte address
//   req_wd   [32]        store data, right-aligned
//   req_dt               access type (mem_dt_e)
//   rsp_valid            one-cycle response pulse
//   rsp_rd   [32]        extended load data, 0 for stores and errors
//   rsp_err  [2]         0 = OK, 1 = RANGE, 2 = ALIGN
//
// States (MEM_LSU_MISALIGNED_EN only):
//   state   | meaning
//   S_IDLE  | ready, accepts one request per cycle
//   S_SPLIT | second word access of a misaligned request, not ready
//
// A reset during S_SPLIT drops the response; the first half of a split store
// may already have been written.

package mem_lsu_pkg;
   typedef enum logic [2:0] {
      MEM_DT_BYTE  = 3'd0,
      MEM_DT_UBYTE = 3'd1,
      MEM_DT_HALF  = 3'd2,
      MEM_DT_UHALF = 3'd3,
      MEM_DT_WORD  = 3'd4
   } mem_dt_e;

   localparam logic [1:0] ERR_OK    = 2'd0;
   localparam logic [1:0] ERR_RANGE = 2'd1;
   localparam logic [1:0] ERR_ALIGN = 2'd2;
endpackage

module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wd,
   input  mem_dt_e       req_dt,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rd,
   output logic [1:0]    rsp_err
);

   localparam int          IW        = $clog2(DEPTH_WORDS);
   localparam logic [AW:0] MEM_BYTES = (AW+1)'(4 * DEPTH_WORDS);

   function automatic logic [2:0] dt_size(input mem_dt_e dt);
      case (dt)
         MEM_DT_BYTE, MEM_DT_UBYTE: return 3'd1;
         MEM_DT_HALF, MEM_DT_UHALF: return 3'd2;
         default:                   return 3'd4;
      endcase
   endfunction

   function automatic logic [3:0] dt_mask(input mem_dt_e dt);
      case (dt)
         MEM_DT_BYTE, MEM_DT_UBYTE: return 4'b0001;
         MEM_DT_HALF, MEM_DT_UHALF: return 4'b0011;
         default:                   return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] extend(input mem_dt_e dt, input logic [31:0] d);
      case (dt)
         MEM_DT_BYTE:  return {{24{d[7]}}, d[7:0]};
         MEM_DT_UBYTE: return {24'd0, d[7:0]};
         MEM_DT_HALF:  return {{16{d[15]}}, d[15:0]};
         MEM_DT_UHALF: return {16'd0, d[15:0]};
         default:      return d;
      endcase
   endfunction

   logic [31:0]   mem_q [DEPTH_WORDS];

   logic [2:0]    size;
   logic [1:0]    off;
   logic [IW-1:0] idx;
   logic [AW:0]   last_byte;
   logic          range_err;
   logic          misal;
   logic [3:0]    be_lo;
   logic [31:0]   wd_lo;
   logic [31:0]   rd_lo;

   logic          wr_en;
   logic [IW-1:0] wr_idx;
   logic [3:0]    wr_be;
   logic [31:0]   wr_data;

   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_rd_q, rsp_rd_d;
   logic [1:0]    rsp_err_q, rsp_err_d;

   assign size      = dt_size(req_dt);
   assign off       = req_addr[1:0];
   assign idx       = req_addr[IW+1:2];
   // One extra bit so addresses near the top of the AW space cannot wrap.
   assign last_byte = {1'b0, req_addr} + (AW+1)'(size) - (AW+1)'(1);
   assign range_err = last_byte >= MEM_BYTES;
   // size-1 masks the offset bits that must be zero (word: size[1:0]-1 = 2'b11).
   assign misal     = |(off & (size[1:0] - 2'd1));
   assign be_lo     = dt_mask(req_dt) << off;
   assign wd_lo     = req_wd << {off, 3'b000};
   assign rd_lo     = mem_q[idx] >> {off, 3'b000};

`ifdef MEM_LSU_MISALIGNED_EN
   typedef enum logic {S_IDLE, S_SPLIT} state_e;

   state_e        state_q, state_d;
   logic          sp_load;
   logic          sp_we_q;
   mem_dt_e       sp_dt_q;
   logic [1:0]    sp_off_q;
   logic [IW-1:0] sp_idx_nx_q;
   logic [3:0]    sp_be_q;
   logic [31:0]   sp_wd_q;
   logic [31:0]   sp_lo_q;
   logic [31:0]   sp_rd;

   assign req_ready = rst_n & (state_q == S_IDLE);

   // sp_off_q is never 0 in S_SPLIT, so the left shift stays below 32.
   assign sp_rd = (sp_lo_q >> {sp_off_q, 3'b000})
                | (mem_q[sp_idx_nx_q] << (6'd32 - {1'b0, sp_off_q, 3'b000}));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Second-half context; the word at A is captured before any write to it.
   always_ff @(posedge clk) begin
      if (sp_load) begin
         sp_we_q     <= req_we;
         sp_dt_q     <= req_dt;
         sp_off_q    <= off;
         sp_idx_nx_q <= idx + IW'(1);
         sp_be_q     <= dt_mask(req_dt) >> (3'd4 - {1'b0, off});
         sp_wd_q     <= req_wd >> (6'd32 - {1'b0, off, 3'b000});
         sp_lo_q     <= mem_q[idx];
      end
   end
`else
   assign req_ready = rst_n;
`endif

   always_comb begin
      rsp_valid_d = 1'b0;
      rsp_rd_d    = '0;
      rsp_err_d   = ERR_OK;
      wr_en       = 1'b0;
      wr_idx      = idx;
      wr_be       = be_lo;
      wr_data     = wd_lo;
`ifdef MEM_LSU_MISALIGNED_EN
      state_d     = state_q;
      sp_load     = 1'b0;
      if (state_q == S_SPLIT) begin
         state_d     = S_IDLE;
         wr_en       = sp_we_q;
         wr_idx      = sp_idx_nx_q;
         wr_be       = sp_be_q;
         wr_data     = sp_wd_q;
         rsp_valid_d = 1'b1;
         rsp_rd_d    = sp_we_q ? '0 : extend(sp_dt_q, sp_rd);
      end else
`endif
      if (req_valid && req_ready) begin
         rsp_valid_d = 1'b1;
         if (range_err) begin
            rsp_err_d = ERR_RANGE;
         end else if (misal) begin
`ifdef MEM_LSU_MISALIGNED_EN
            rsp_valid_d = 1'b0;
            wr_en       = req_we;
            sp_load     = 1'b1;
            state_d     = S_SPLIT;
`else
            rsp_err_d   = ERR_ALIGN;
`endif
         end else begin
            wr_en    = req_we;
            rsp_rd_d = req_we ? '0 : extend(req_dt, rd_lo);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
               mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_rd_q    <= '0;
         rsp_err_q   <= ERR_OK;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rd    = rsp_rd_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu. Expected responses are queued when a request is
// driven and compared, including their arrival cycle, when rsp_valid pulses.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   localparam int DEPTH_WORDS = 64;
   localparam int AW          = 32;

`ifdef MEM_LSU_MISALIGNED_EN
   localparam int         MIS_LAT = 2;
   localparam logic [1:0] MIS_ERR = 2'd0;
`else
   localparam int         MIS_LAT = 1;
   localparam logic [1:0] MIS_ERR = 2'd2;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wd;
   mem_dt_e       req_dt;
   logic          rsp_valid;
   logic [31:0]   rsp_rd;
   logic [1:0]    rsp_err;

   typedef struct {
      logic [31:0] rd;
      logic [1:0]  err;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   mem_lsu #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wd    (req_wd),
      .req_dt    (req_dt),
      .rsp_valid (rsp_valid),
      .rsp_rd    (rsp_rd),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid) begin
         check("rsp_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_rd", rsp_rd, e.rd);
            check("rsp_err", {30'd0, rsp_err}, {30'd0, e.err});
            check("rsp_cycle", cyc, e.due);
         end
      end else if (sb.size() != 0) begin
         check("rsp_pending", 32'(cyc < sb[0].due), 32'd1);
         if (cyc >= sb[0].due) void'(sb.pop_front());
      end
   end

   // Called at posedge+1; the request is accepted at the next edge.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input mem_dt_e dt, input logic [31:0] want_rd,
                        input logic [1:0] want_err, input int lat, input bit track);
      check("req_ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wd    = wd;
      req_dt    = dt;
      if (track) sb.push_back('{rd: want_rd, err: want_err, due: cyc + lat});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic st(input mem_dt_e dt, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] want_err, input int lat);
      issue(1'b1, addr, wd, dt, 32'd0, want_err, lat, 1'b1);
   endtask

   task automatic ld(input mem_dt_e dt, input logic [31:0] addr, input logic [31:0] want_rd,
                     input logic [1:0] want_err, input int lat);
      issue(1'b0, addr, 32'd0, dt, want_rd, want_err, lat, 1'b1);
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

`ifdef MEM_LSU_MISALIGNED_EN
   // During SPLIT: not ready, and request fields are scrambled to show they
   // are not resampled.
   task automatic split_gap();
      check("split_ready_low", {31'd0, req_ready}, 32'd0);
      req_we   = 1'b1;
      req_addr = '0;
      req_wd   = 32'hffff_ffff;
      req_dt   = MEM_DT_BYTE;
      idle(1);
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wd    = '0;
      req_dt    = MEM_DT_WORD;
      #3;
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rd", rsp_rd, 32'd0);
      check("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("post_rst_ready", {31'd0, req_ready}, 32'd1);

      // Half store into the upper lanes of word 12.
      st(MEM_DT_WORD, 32'd48, 32'h1234_5678, 2'd0, 1);
      st(MEM_DT_HALF, 32'd50, 32'h0000_dead, 2'd0, 1);
      ld(MEM_DT_WORD, 32'd48, 32'hdead_5678, 2'd0, 1);

      // Load extension.
      st(MEM_DT_WORD,  32'd48, 32'h8284_8688, 2'd0, 1);
      ld(MEM_DT_BYTE,  32'd49, 32'hffff_ff86, 2'd0, 1);
      ld(MEM_DT_UBYTE, 32'd49, 32'h0000_0086, 2'd0, 1);
      ld(MEM_DT_HALF,  32'd50, 32'hffff_8284, 2'd0, 1);
      ld(MEM_DT_UHALF, 32'd50, 32'h0000_8284, 2'd0, 1);
      ld(MEM_DT_BYTE,  32'd48, 32'hffff_ff88, 2'd0, 1);
      ld(MEM_DT_UBYTE, 32'd51, 32'h0000_0082, 2'd0, 1);
      ld(MEM_DT_HALF,  32'd48, 32'hffff_8688, 2'd0, 1);

      // Back-to-back store then load of the same word.
      st(MEM_DT_WORD, 32'd8, 32'hcafe_f00d, 2'd0, 1);
      ld(MEM_DT_WORD, 32'd8, 32'hcafe_f00d, 2'd0, 1);
      idle(1);

      // Top of memory and range errors.
      ld(MEM_DT_WORD,  32'd256,       32'd0,         2'd1, 1);
      st(MEM_DT_WORD,  32'd252,       32'h0102_0304, 2'd0, 1);
      st(MEM_DT_HALF,  32'd254,       32'h0000_beef, 2'd0, 1);
      st(MEM_DT_WORD,  32'd254,       32'h1111_1111, 2'd1, 1);
      ld(MEM_DT_WORD,  32'd252,       32'hbeef_0304, 2'd0, 1);
      ld(MEM_DT_BYTE,  32'd255,       32'hffff_ffbe, 2'd0, 1);
      ld(MEM_DT_BYTE,  32'd256,       32'd0,         2'd1, 1);
      ld(MEM_DT_WORD,  32'd253,       32'd0,         2'd1, 1);
      ld(MEM_DT_WORD,  32'hffff_fffd, 32'd0,         2'd1, 1);
      st(MEM_DT_UBYTE, 32'hffff_ffff, 32'h0000_00aa, 2'd1, 1);
      ld(MEM_DT_WORD,  32'd252,       32'hbeef_0304, 2'd0, 1);

      // Misaligned word store across words 12 and 13.
      st(MEM_DT_WORD, 32'd48, 32'h1122_3344, 2'd0, 1);
      st(MEM_DT_WORD, 32'd52, 32'h5566_7788, 2'd0, 1);
      st(MEM_DT_WORD, 32'd51, 32'haabb_ccdd, MIS_ERR, MIS_LAT);
`ifdef MEM_LSU_MISALIGNED_EN
      split_gap();
      ld(MEM_DT_WORD, 32'd48, 32'hdd22_3344, 2'd0, 1);
      ld(MEM_DT_WORD, 32'd52, 32'h55aa_bbcc, 2'd0, 1);
      ld(MEM_DT_WORD, 32'd51, 32'haabb_ccdd, 2'd0, 2);
      split_gap();
      ld(MEM_DT_HALF, 32'd51, 32'hffff_ccdd, 2'd0, 2);
      split_gap();
      ld(MEM_DT_HALF, 32'd49, 32'h0000_2233, 2'd0, 2);
      split_gap();
      ld(MEM_DT_HALF, 32'd253, 32'hffff_ef03, 2'd0, 2);
      split_gap();

      // Reset while a misaligned load is in SPLIT: no response may appear.
      issue(1'b0, 32'd51, 32'd0, MEM_DT_WORD, 32'd0, 2'd0, 2, 1'b0);
      check("split_ready_low", {31'd0, req_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("midrst_rsp_rd", rsp_rd, 32'd0);
      check("midrst_rsp_err", {30'd0, rsp_err}, 32'd0);
      check("midrst_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("midrst_rsp_valid_held", {31'd0, rsp_valid}, 32'd0);
      rst_n = 1'b1;
      check("midrst_ready_after", {31'd0, req_ready}, 32'd1);
      idle(3);
      ld(MEM_DT_WORD, 32'd48, 32'hdd22_3344, 2'd0, 1);
`else
      ld(MEM_DT_WORD, 32'd48,  32'h1122_3344, 2'd0, 1);
      ld(MEM_DT_WORD, 32'd52,  32'h5566_7788, 2'd0, 1);
      ld(MEM_DT_WORD, 32'd51,  32'd0,         2'd2, 1);
      ld(MEM_DT_HALF, 32'd49,  32'd0,         2'd2, 1);
      ld(MEM_DT_HALF, 32'd253, 32'd0,         2'd2, 1);
      st(MEM_DT_HALF, 32'd255, 32'h0000_1234, 2'd1, 1);
      ld(MEM_DT_UHALF, 32'd50, 32'h0000_1122, 2'd0, 1);
`endif

      idle(4);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
